// File: rtl/pipelined_decode_unit.sv
// Decode stage of a five-stage pipeline: IF/ID register, register file with
// write-through bypass, load-use hazard detection and the ID/EX register.
module pipelined_decode_unit #(
  parameter int NB_DATA     = 32,
  parameter int NB_REGISTER = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [31:0]            i_instruction,
  input  logic [NB_DATA-1:0]     i_pc_next,
  input  logic                   i_flush,
  input  logic                   i_ex_mem_read,
  input  logic [NB_REGISTER-1:0] i_ex_rt,
  input  logic                   i_wb_write_enable,
  input  logic [NB_REGISTER-1:0] i_wb_reg_sel,
  input  logic [NB_DATA-1:0]     i_wb_data,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [NB_DATA-1:0]     o_pc_next,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct,
  output logic [NB_REGISTER-1:0] o_rs,
  output logic [NB_REGISTER-1:0] o_rt,
  output logic [NB_REGISTER-1:0] o_rd,
  output logic [NB_REGISTER-1:0] o_sa,
  output logic [NB_DATA-1:0]     o_data_rs,
  output logic [NB_DATA-1:0]     o_data_rt,
  output logic [NB_DATA-1:0]     o_extended,
  output logic [25:0]            o_instruction_index
);

  localparam int N_REGS = 2 ** NB_REGISTER;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  logic [31:0]            ifid_instruction;
  logic [NB_DATA-1:0]     ifid_pc_next;
  logic                   ifid_valid;

  logic [NB_REGISTER-1:0] id_rs;
  logic [NB_REGISTER-1:0] id_rt;
  logic [NB_REGISTER-1:0] id_rd;
  logic [NB_REGISTER-1:0] id_sa;
  logic [15:0]            id_imm;

  logic [NB_DATA-1:0]     regs [N_REGS];
  logic [NB_DATA-1:0]     read_rs;
  logic [NB_DATA-1:0]     read_rt;
  logic [NB_DATA-1:0]     extended;
  logic                   wb_active;
  logic                   stall;
  logic                   bubble;

  // Register fields are zero-extended or truncated to the register-select width.
  assign id_rs  = NB_REGISTER'(ifid_instruction[25:21]);
  assign id_rt  = NB_REGISTER'(ifid_instruction[20:16]);
  assign id_rd  = NB_REGISTER'(ifid_instruction[15:11]);
  assign id_sa  = NB_REGISTER'(ifid_instruction[10:6]);
  assign id_imm = ifid_instruction[15:0];

  always_comb begin
    stall = 1'b0;
    if (!i_reset && ifid_valid && i_ex_mem_read && (i_ex_rt != '0)) begin
      stall = (i_ex_rt == id_rs) || (i_ex_rt == id_rt);
    end
  end

  assign o_stall = stall;
  assign bubble  = i_flush || stall || !ifid_valid;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ifid_instruction <= '0;
      ifid_pc_next     <= '0;
      ifid_valid       <= 1'b0;
    end else if (i_flush) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_instruction <= i_instruction;
      ifid_pc_next     <= i_pc_next;
      ifid_valid       <= i_valid;
    end
  end

  // Writeback is independent of the decode pipeline state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_active) begin
      regs[i_wb_reg_sel] <= i_wb_data;
    end
  end

  assign wb_active = i_wb_write_enable && (i_wb_reg_sel != '0);

  always_comb begin
    read_rs = regs[id_rs];
    if (id_rs == '0) begin
      read_rs = '0;
    end else if (wb_active && (i_wb_reg_sel == id_rs)) begin
      read_rs = i_wb_data;
    end
  end

  always_comb begin
    read_rt = regs[id_rt];
    if (id_rt == '0) begin
      read_rt = '0;
    end else if (wb_active && (i_wb_reg_sel == id_rt)) begin
      read_rt = i_wb_data;
    end
  end

  // Logical immediates are zero-extended; everything else sign-extends.
  always_comb begin
    extended = {{(NB_DATA-16){id_imm[15]}}, id_imm};
    case (ifid_instruction[31:26])
      OP_ANDI, OP_ORI, OP_XORI: extended = {{(NB_DATA-16){1'b0}}, id_imm};
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || bubble) begin
      o_valid             <= 1'b0;
      o_pc_next           <= '0;
      o_opcode            <= '0;
      o_funct             <= '0;
      o_rs                <= '0;
      o_rt                <= '0;
      o_rd                <= '0;
      o_sa                <= '0;
      o_data_rs           <= '0;
      o_data_rt           <= '0;
      o_extended          <= '0;
      o_instruction_index <= '0;
    end else begin
      o_valid             <= 1'b1;
      o_pc_next           <= ifid_pc_next;
      o_opcode            <= ifid_instruction[31:26];
      o_funct             <= ifid_instruction[5:0];
      o_rs                <= id_rs;
      o_rt                <= id_rt;
      o_rd                <= id_rd;
      o_sa                <= id_sa;
      o_data_rs           <= read_rs;
      o_data_rt           <= read_rt;
      o_extended          <= extended;
      o_instruction_index <= ifid_instruction[25:0];
    end
  end

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// Directed and randomized checks of pipelined_decode_unit against a
// behavioural model of the decode stage.
module tb_pipelined_decode_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic [31:0] i_pc_next;
  logic        i_flush;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        i_wb_write_enable;
  logic [4:0]  i_wb_reg_sel;
  logic [31:0] i_wb_data;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_pc_next;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [4:0]  o_sa;
  logic [31:0] o_data_rs;
  logic [31:0] o_data_rt;
  logic [31:0] o_extended;
  logic [25:0] o_instruction_index;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;

  logic        e_valid;
  logic [31:0] e_pc;
  logic [57:0] e_fields;
  logic [31:0] e_rs_data;
  logic [31:0] e_rt_data;
  logic [31:0] e_ext;

  pipelined_decode_unit #(.NB_DATA(32), .NB_REGISTER(5)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_instruction(i_instruction), .i_pc_next(i_pc_next), .i_flush(i_flush),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .i_wb_write_enable(i_wb_write_enable), .i_wb_reg_sel(i_wb_reg_sel),
    .i_wb_data(i_wb_data), .o_stall(o_stall), .o_valid(o_valid),
    .o_pc_next(o_pc_next), .o_opcode(o_opcode), .o_funct(o_funct),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_sa(o_sa),
    .o_data_rs(o_data_rs), .o_data_rt(o_data_rt), .o_extended(o_extended),
    .o_instruction_index(o_instruction_index)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    logic [4:0] a = 5'(rs);
    logic [4:0] b = 5'(rt);
    logic [4:0] c = 5'(rd);
    return {6'h00, a, b, c, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    logic [4:0] a = 5'(rs);
    logic [4:0] b = 5'(rt);
    return {op, a, b, imm};
  endfunction

  // What a read port should return this cycle, writeback forwarding included.
  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
    if (i_wb_write_enable && i_wb_reg_sel == addr) return i_wb_data;
    return m_regs[addr];
  endfunction

  task automatic idle();
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_instruction = $urandom;
    i_pc_next = $urandom;
    i_flush = 1'b0;
    i_ex_mem_read = 1'b0;
    i_ex_rt = 5'd0;
    i_wb_write_enable = 1'b0;
    i_wb_reg_sel = 5'd0;
    i_wb_data = $urandom;
  endtask

  // One clock: check the hazard output, predict the next state, clock, compare.
  task automatic step();
    logic       exp_stall;
    logic       bub;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] op;
    #1;
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    op = m_instr[31:26];
    exp_stall = !i_reset && m_valid && i_ex_mem_read && i_ex_rt != 0 &&
                (i_ex_rt == rs || i_ex_rt == rt);
    chk("stall", o_stall, exp_stall);
    bub = i_reset || i_flush || exp_stall || !m_valid;
    if (bub) begin
      e_valid = 0; e_pc = 0; e_fields = 0; e_rs_data = 0; e_rt_data = 0; e_ext = 0;
    end else begin
      e_valid   = 1;
      e_pc      = m_pc;
      e_fields  = {op, m_instr[5:0], rs, rt, m_instr[15:11], m_instr[10:6], m_instr[25:0]};
      e_rs_data = model_read(rs);
      e_rt_data = model_read(rt);
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e_ext = {16'h0, m_instr[15:0]};
      else e_ext = {{16{m_instr[15]}}, m_instr[15:0]};
    end
    if (i_reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_instr = 0; m_pc = 0; m_valid = 0;
    end else begin
      if (i_wb_write_enable && i_wb_reg_sel != 0) m_regs[i_wb_reg_sel] = i_wb_data;
      if (i_flush) m_valid = 0;
      else if (!exp_stall) begin
        m_instr = i_instruction; m_pc = i_pc_next; m_valid = i_valid;
      end
    end
    @(posedge i_clock);
    #1;
    chk("valid", o_valid, e_valid);
    chk("pc_next", o_pc_next, e_pc);
    chk("fields", {o_opcode, o_funct, o_rs, o_rt, o_rd, o_sa, o_instruction_index}, e_fields);
    chk("data_rs", o_data_rs, e_rs_data);
    chk("data_rt", o_data_rt, e_rt_data);
    chk("extended", o_extended, e_ext);
  endtask

  initial begin
    logic [31:0] w;
    logic [5:0]  ops [6];
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0C;
    ops[3] = 6'h0D; ops[4] = 6'h0E; ops[5] = 6'h23;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_instr = 0; m_pc = 0; m_valid = 0;

    // reset with a write and a valid fetch presented: both are discarded
    idle();
    i_reset = 1; i_valid = 1; i_wb_write_enable = 1; i_wb_reg_sel = 5; i_wb_data = 32'hCAFE;
    step();
    step();
    chk("reset_valid", o_valid, 0);
    chk("reset_stall", o_stall, 0);
    idle(); step();
    idle(); i_valid = 1; i_instruction = rtype(5, 0, 1); step();
    idle(); step();
    chk("reset_write_dropped", o_data_rs, 0);

    // write-then-read
    idle(); i_wb_write_enable = 1; i_wb_reg_sel = 5; i_wb_data = 32'h1234_5678; step();
    idle(); i_valid = 1; i_instruction = rtype(5, 0, 3); step();
    idle(); step();
    chk("wr_rd_rs", o_data_rs, 32'h1234_5678);
    chk("wr_rd_rt", o_data_rt, 0);
    chk("wr_rd_valid", o_valid, 1);

    // same-cycle bypass
    idle(); i_valid = 1; i_instruction = rtype(7, 0, 2); step();
    idle(); i_wb_write_enable = 1; i_wb_reg_sel = 7; i_wb_data = 32'hDEAD_BEEF; step();
    chk("bypass_rs", o_data_rs, 32'hDEAD_BEEF);

    // load-use stall then release
    idle(); i_valid = 1; i_instruction = rtype(1, 4, 2); step();
    i_instruction = rtype(3, 3, 3); i_ex_mem_read = 1; i_ex_rt = 4; step();
    chk("loaduse_bubble", o_valid, 0);
    chk("loaduse_stall", o_stall, 1);
    step();
    i_ex_mem_read = 0; step();
    chk("loaduse_issue", o_valid, 1);
    chk("loaduse_rt", o_rt, 4);

    // flush during stall
    idle(); i_valid = 1; i_instruction = rtype(4, 1, 2); step();
    i_ex_mem_read = 1; i_ex_rt = 4; i_flush = 1; i_instruction = $urandom; step();
    chk("flush_valid", o_valid, 0);
    chk("flush_stall", o_stall, 0);

    // immediate extension and r0
    idle(); i_valid = 1; i_instruction = itype(6'h0D, 0, 1, 16'h8001); step();
    i_instruction = itype(6'h08, 0, 1, 16'h8001); step();
    chk("ori_ext", o_extended, 32'h0000_8001);
    idle(); step();
    chk("addi_ext", o_extended, 32'hFFFF_8001);
    idle(); i_wb_write_enable = 1; i_wb_reg_sel = 0; i_wb_data = 32'hFFFF_FFFF; step();
    idle(); i_valid = 1; i_instruction = rtype(0, 0, 1); step();
    idle(); step();
    chk("r0_rs", o_data_rs, 0);
    chk("r0_rt", o_data_rt, 0);

    // randomized traffic with small register ranges to force collisions
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 5)];
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      i_reset = ($urandom_range(0, 49) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_instruction = w;
      i_pc_next = $urandom;
      i_flush = ($urandom_range(0, 9) == 0);
      i_ex_mem_read = ($urandom_range(0, 2) == 0);
      i_ex_rt = 5'($urandom_range(0, 7));
      i_wb_write_enable = 1'($urandom_range(0, 1));
      i_wb_reg_sel = 5'($urandom_range(0, 7));
      i_wb_data = $urandom;
      step();
    end

    // reset mid-stream with both stages occupied
    idle(); i_wb_write_enable = 1; i_wb_reg_sel = 9; i_wb_data = 32'h55; step();
    idle(); i_valid = 1; i_instruction = rtype(9, 9, 1); step();
    i_instruction = rtype(9, 0, 2); step();
    chk("pre_reset_valid", o_valid, 1);
    i_reset = 1; step();
    chk("midreset_valid", o_valid, 0);
    chk("midreset_data", o_data_rs, 0);
    idle(); i_valid = 1; i_instruction = rtype(9, 9, 3); step();
    idle(); step();
    chk("post_reset_valid", o_valid, 1);
    chk("post_reset_r9", o_data_rs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
